stop_watch_ctrl: RTL and testbench

//  Button-driven sequencer for the 3-digit BCD stopwatch datapath (0.1 s resolution, 000..999).

---
 rtl/stop_watch_ctrl.sv | 103 ++++++++++
 tb/tb_stop_watch_ctrl.sv | 138 +++++++++++++
 2 files changed

// File: rtl/stop_watch_ctrl.sv
// Start/stop and lap/reset sequencer for the 3-digit BCD stopwatch, with button lockout and lap freeze.
// Optional macro AUTO_STOP_EN: stop at 999 instead of letting the datapath wrap.
module stop_watch_ctrl #(
  parameter int DW      = 4,
  parameter int LOCKOUT = 16
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          btn_ss,
  input  logic          btn_lr,
  input  logic [DW-1:0] d2,
  input  logic [DW-1:0] d1,
  input  logic [DW-1:0] d0,
  output logic          go,
  output logic          clr,
  output logic [DW-1:0] q2,
  output logic [DW-1:0] q1,
  output logic [DW-1:0] q0,
  output logic          running,
  output logic          lap_act
);

  localparam int CW = (LOCKOUT > 0) ? $clog2(LOCKOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE, RUN, LAP, PAUSE} state_t;

  state_t        state;
  logic [DW-1:0] lap2, lap1, lap0;
  logic [CW-1:0] lock_cnt;
  logic          clr_reg;
  logic          unlocked, ev_ss, ev_lr, auto_stop;

  // start/stop wins a simultaneous press; the lap/reset pulse is simply lost
  assign unlocked = (lock_cnt == '0);
  assign ev_ss    = btn_ss && unlocked;
  assign ev_lr    = btn_lr && !btn_ss && unlocked;

`ifdef AUTO_STOP_EN
  assign auto_stop = ((state == RUN) || (state == LAP)) &&
                     (d2 == DW'(9)) && (d1 == DW'(9)) && (d0 == DW'(9));
`else
  assign auto_stop = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= IDLE;
      lap2     <= '0;
      lap1     <= '0;
      lap0     <= '0;
      lock_cnt <= '0;
      clr_reg  <= 1'b1;
    end else begin
      clr_reg <= 1'b0;
      // an auto-stop is not a button event, so it leaves the lockout alone
      if (!auto_stop && (ev_ss || ev_lr))
        lock_cnt <= CW'(LOCKOUT);
      else if (!unlocked)
        lock_cnt <= lock_cnt - CW'(1);

      if (auto_stop) begin
        state <= PAUSE;
      end else if (ev_ss) begin
        case (state)
          IDLE:    state <= RUN;
          RUN:     state <= PAUSE;
          LAP:     state <= PAUSE;
          PAUSE:   state <= RUN;
          default: state <= IDLE;
        endcase
      end else if (ev_lr) begin
        case (state)
          IDLE: begin
            state   <= IDLE;
            clr_reg <= 1'b1;
          end
          RUN: begin
            state <= LAP;
            lap2  <= d2;
            lap1  <= d1;
            lap0  <= d0;
          end
          LAP: state <= RUN;
          PAUSE: begin
            state   <= IDLE;
            clr_reg <= 1'b1;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign go      = (state == RUN) || (state == LAP);
  assign running = go;
  assign lap_act = (state == LAP);
  assign clr     = clr_reg;

  assign q2 = lap_act ? lap2 : d2;
  assign q1 = lap_act ? lap1 : d1;
  assign q0 = lap_act ? lap0 : d0;

endmodule

// File: tb/tb_stop_watch_ctrl.sv
// Directed plus random button sequences against a mode-level stopwatch model.
module tb_stop_watch_ctrl;
  localparam int DW = 4;
  localparam int LOCKOUT = 16;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          btn_ss = 1'b0, btn_lr = 1'b0;
  logic [DW-1:0] d2 = '0, d1 = '0, d0 = '0;
  logic          go, clr, running, lap_act;
  logic [DW-1:0] q2, q1, q0;

  stop_watch_ctrl #(.DW(DW), .LOCKOUT(LOCKOUT)) dut (
    .clk(clk), .reset_n(reset_n), .btn_ss(btn_ss), .btn_lr(btn_lr),
    .d2(d2), .d1(d1), .d0(d0), .go(go), .clr(clr),
    .q2(q2), .q1(q1), .q0(q0), .running(running), .lap_act(lap_act)
  );

  always #5 clk = ~clk;

  // model: counting / lap-frozen / paused flags, time of last accepted press
  bit         m_count, m_lap, m_paused, m_clr;
  logic [11:0] m_lapv;
  int         cyc, last_acc;
  int         checks = 0, passed = 0;

  task automatic model_edge(input logic ss, input logic lr, input logic [11:0] dv, input logic rst);
    bit stop999;
    cyc++;
    if (!rst) begin
      m_count = 0; m_lap = 0; m_paused = 0; m_clr = 1; m_lapv = '0; last_acc = -1000;
      return;
    end
    m_clr = 0;
`ifdef AUTO_STOP_EN
    stop999 = m_count && (dv == 12'h999);
`else
    stop999 = 0;
`endif
    if (stop999) begin
      m_count = 0; m_lap = 0; m_paused = 1;
    end else if ((ss || lr) && (cyc - last_acc > LOCKOUT)) begin
      last_acc = cyc;
      if (ss) begin
        if (m_count) begin m_count = 0; m_lap = 0; m_paused = 1; end
        else begin m_count = 1; m_paused = 0; end
      end else if (!m_count) begin
        m_paused = 0; m_clr = 1;
      end else if (m_lap) begin
        m_lap = 0;
      end else begin
        m_lap = 1; m_lapv = dv;
      end
    end
  endtask

  task automatic check(input string tag);
    logic [11:0] exp_q;
    exp_q = m_lap ? m_lapv : {d2, d1, d0};
    checks++;
    assert ({go, running, lap_act} === {m_count, m_count, m_lap}) passed++;
    else $error("FAIL %s mode: got go/run/lap=%b%b%b exp %b%b%b", tag, go, running, lap_act, m_count, m_count, m_lap);
    checks++;
    assert (clr === m_clr) passed++;
    else $error("FAIL %s clr: got %b exp %b", tag, clr, m_clr);
    checks++;
    assert ({q2, q1, q0} === exp_q) passed++;
    else $error("FAIL %s q: got %h exp %h", tag, {q2, q1, q0}, exp_q);
  endtask

  task automatic step(input string tag, input logic ss, input logic lr, input logic [11:0] dv, input logic rst = 1'b1);
    @(negedge clk);
    btn_ss = ss; btn_lr = lr; {d2, d1, d0} = dv; reset_n = rst;
    @(posedge clk);
    model_edge(ss, lr, dv, rst);
    #1 check(tag);
  endtask

  task automatic idle(input string tag, input int n, input logic [11:0] dv);
    for (int i = 0; i < n; i++) step(tag, 1'b0, 1'b0, dv);
  endtask

  initial begin
    cyc = 0; last_acc = -1000;
    // reset with buttons pressed: they must be ignored
    step("rst0", 1'b1, 1'b0, 12'h000, 1'b0);
    step("rst1", 1'b0, 1'b1, 12'h000, 1'b0);
    step("rst2", 1'b0, 1'b0, 12'h000, 1'b0);
    step("rel", 1'b0, 1'b0, 12'h000);
    idle("idle", 2, 12'h000);

    // start, stop after lockout, reset from pause
    step("ss_start", 1'b1, 1'b0, 12'h000);
    idle("run", 17, 12'h001);
    step("ss_stop", 1'b1, 1'b0, 12'h012);
    idle("pause", 17, 12'h012);
    step("lr_clr", 1'b0, 1'b1, 12'h012);
    idle("cleared", 17, 12'h000);

    // lap freeze and release
    step("ss_run", 1'b1, 1'b0, 12'h000);
    idle("run2", 17, 12'h347);
    step("lap_cap", 1'b0, 1'b1, 12'h347);
    idle("lap_hold", 17, 12'h502);
    step("lap_rel", 1'b0, 1'b1, 12'h502);
    idle("live", 17, 12'h503);

    // simultaneous press: stop wins, no clear, lap regs untouched
    step("both", 1'b1, 1'b1, 12'h510);
    idle("both_pause", 17, 12'h510);

    // lockout window boundary
    step("ss_go", 1'b1, 1'b0, 12'h510);
    idle("lk", 4, 12'h511);
    step("ss_locked", 1'b1, 1'b0, 12'h511);
    idle("lk2", 10, 12'h512);
    step("ss_at16", 1'b1, 1'b0, 12'h512);
    step("ss_at17", 1'b1, 1'b0, 12'h512);
    idle("lk3", 17, 12'h512);

    // reach 999 while running (stop only with AUTO_STOP_EN)
    step("ss_run3", 1'b1, 1'b0, 12'h998);
    idle("to999", 3, 12'h999);
    idle("wrap", 3, 12'h000);

    // random presses and digits
    for (int i = 0; i < 3000; i++) begin
      logic [11:0] dv;
      dv = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      if ($urandom_range(0, 40) == 0) dv = 12'h999;
      step("rand", ($urandom_range(0, 7) == 0), ($urandom_range(0, 6) == 0), dv,
           ($urandom_range(0, 400) != 0));
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
